// File: rtl/ggt_sequencer.sv
`timescale 1ns/1ps
// Euclidean GCD sequencer: drives an external modulo stage (a mod b) repeatedly
// until the remainder is zero, with a per-request watchdog and an iteration cap.
module ggt_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] Zahl1_i,
  input  logic [WIDTH-1:0] Zahl2_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] ergebnis_o,
  output logic             error_o,
  output logic [5:0]       iter_o,
  output logic             mod_start_o,
  output logic [WIDTH-1:0] mod_zahl1_o,
  output logic [WIDTH-1:0] mod_zahl2_o,
  input  logic             mod_valid_i,
  input  logic [WIDTH-1:0] mod_ergebnis_i
);

  // Watchdog only has to count 0..TIMEOUT-1 before firing.
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [5:0]      ITER_MAX = 6'd63;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic             start_prev_q;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [5:0]       iter_q, iter_d;
  logic             start_edge;

  assign start_edge = start_i && !start_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      wd_q         <= '0;
      res_q        <= '0;
      err_q        <= 1'b0;
      iter_q       <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_i;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      res_q        <= res_d;
      err_q        <= err_d;
      iter_q       <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    res_d   = res_q;
    err_d   = err_q;
    iter_d  = iter_q;

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          a_d   = Zahl1_i;
          b_d   = Zahl2_i;
          cnt_d = '0;
          wd_d  = '0;
          if (Zahl2_i == '0) begin
            // gcd(a,0)=a; gcd(0,0) is undefined and flagged (result is 0 either way).
            state_d = DONE;
            res_d   = Zahl1_i;
            err_d   = (Zahl1_i == '0);
            iter_d  = '0;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (cnt_q != ITER_MAX) cnt_d = cnt_q + 6'd1;
        wd_d    = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (mod_valid_i) begin
          if (mod_ergebnis_i == '0) begin
            state_d = DONE;
            res_d   = b_q;
            err_d   = 1'b0;
            iter_d  = cnt_q;
          end else if (cnt_q == ITER_MAX) begin
            state_d = DONE;
            res_d   = '0;
            err_d   = 1'b1;
            iter_d  = cnt_q;
          end else begin
            a_d     = b_q;
            b_d     = mod_ergebnis_i;
            state_d = ISSUE;
          end
        end else if (wd_q == WD_LAST) begin
          state_d = DONE;
          res_d   = '0;
          err_d   = 1'b1;
          iter_d  = cnt_q;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q == ISSUE) || (state_q == WAIT);
  assign valid_o     = (state_q == DONE);
  assign mod_start_o = (state_q == ISSUE);
  assign mod_zahl1_o = a_q;
  assign mod_zahl2_o = b_q;
  assign ergebnis_o  = res_q;
  assign error_o     = err_q;
  assign iter_o      = iter_q;

endmodule

// File: tb/tb_ggt_sequencer.sv
`timescale 1ns/1ps
// Directed bench for ggt_sequencer with a behavioural 3-cycle modulo stage.
module tb_ggt_sequencer;

  localparam int W  = 16;
  localparam int TO = 1023;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [W-1:0]  Zahl1_i, Zahl2_i;
  logic          busy_o, valid_o, error_o, mod_start_o;
  logic [W-1:0]  ergebnis_o, mod_zahl1_o, mod_zahl2_o;
  logic [5:0]    iter_o;
  logic          mod_valid_i;
  logic [W-1:0]  mod_ergebnis_i;

  ggt_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .Zahl1_i(Zahl1_i), .Zahl2_i(Zahl2_i),
    .busy_o(busy_o), .valid_o(valid_o), .ergebnis_o(ergebnis_o),
    .error_o(error_o), .iter_o(iter_o),
    .mod_start_o(mod_start_o), .mod_zahl1_o(mod_zahl1_o), .mod_zahl2_o(mod_zahl2_o),
    .mod_valid_i(mod_valid_i), .mod_ergebnis_i(mod_ergebnis_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Behavioural modulo stage: result valid exactly 3 cycles after mod_start_o.
  bit           model_en = 1'b1;
  bit           model_fake = 1'b0;
  int           pend = 0;
  logic [W-1:0] pend_r;
  logic [W-1:0] pa_q[$];
  logic [W-1:0] pb_q[$];
  logic [W-1:0] rem_q[$];

  initial begin
    mod_valid_i    = 1'b0;
    mod_ergebnis_i = '0;
    pend_r         = '0;
    forever begin
      @(posedge clk);
      #1;
      mod_valid_i = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mod_valid_i    = 1'b1;
          mod_ergebnis_i = pend_r;
          rem_q.push_back(pend_r);
        end
      end
      if (mod_start_o && model_en) begin
        if (model_fake)              pend_r = 16'd1;
        else if (mod_zahl2_o == '0)  pend_r = '0;
        else                         pend_r = mod_zahl1_o % mod_zahl2_o;
        pa_q.push_back(mod_zahl1_o);
        pb_q.push_back(mod_zahl2_o);
        pend = 3;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

  // Results of the last run_job
  bit           r_got, r_first_ms, r_busy_prev, r_busy_at_v, r_stable;
  int           r_lat, r_kz, r_nmods;
  logic [W-1:0] r_res;
  logic         r_err;
  logic [5:0]   r_iter;

  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold, input int budget);
    bit prev_busy;
    r_got = 0; r_first_ms = 0; r_busy_prev = 0; r_busy_at_v = 0; r_stable = 1;
    r_lat = 0; r_kz = -1; r_nmods = 0; r_res = '0; r_err = 1'b0; r_iter = '0;
    pa_q.delete(); pb_q.delete(); rem_q.delete();
    Zahl1_i = a;
    Zahl2_i = b;
    start_i = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      prev_busy = busy_o;
      @(negedge clk);
      if (!hold) start_i = 1'b0;
      if (k == 1) r_first_ms = mod_start_o;
      if (mod_start_o) r_nmods++;
      if (busy_o && !mod_start_o && pa_q.size() > 0 &&
          (mod_zahl1_o != pa_q[$] || mod_zahl2_o != pb_q[$])) r_stable = 0;
      if (busy_o && mod_valid_i && mod_ergebnis_i == '0) r_kz = k;
      if (valid_o) begin
        r_got = 1; r_lat = k; r_busy_prev = prev_busy; r_busy_at_v = busy_o;
        r_res = ergebnis_o; r_err = error_o; r_iter = iter_o;
        break;
      end
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         err;
    logic [5:0]   iter;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  int   exp_rem[8];
  int   exp_pa[3];
  int   exp_pb[3];
  int   nvalid, nms;
  bit   quiet;

  initial begin
    vecs[0] = '{16'd24255, 16'd9540,  16'd45,    1'b0, 6'd8};
    vecs[1] = '{16'd12,    16'd18,    16'd6,     1'b0, 6'd3};
    vecs[2] = '{16'd7,     16'd0,     16'd7,     1'b0, 6'd0};
    vecs[3] = '{16'd0,     16'd0,     16'd0,     1'b1, 6'd0};
    vecs[4] = '{16'd0,     16'd5,     16'd5,     1'b0, 6'd1};
    vecs[5] = '{16'd17,    16'd5,     16'd1,     1'b0, 6'd3};
    vecs[6] = '{16'd65535, 16'd65535, 16'd65535, 1'b0, 6'd1};
    vecs[7] = '{16'd100,   16'd75,    16'd25,    1'b0, 6'd2};
    vecs[8] = '{16'd46368, 16'd28657, 16'd1,     1'b0, 6'd22};
    exp_rem = '{5175, 4365, 810, 315, 180, 135, 45, 0};
    exp_pa  = '{12, 18, 12};
    exp_pb  = '{18, 12, 6};

    // Reset with start_i already high: one job after release, none repeated.
    rst = 1'b0; start_i = 1'b1; Zahl1_i = 16'd100; Zahl2_i = 16'd75;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_error", 32'(error_o), 0);
    chk("rst_modstart", 32'(mod_start_o), 0);
    chk("rst_ergebnis", 32'(ergebnis_o), 0);
    chk("rst_iter", 32'(iter_o), 0);
    chk("rst_zahl1", 32'(mod_zahl1_o), 0);
    chk("rst_zahl2", 32'(mod_zahl2_o), 0);
    rst = 1'b1;
    nvalid = 0; nms = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mod_start_o) nms++;
      if (valid_o) begin
        nvalid++;
        chk("held_start_result", 32'(ergebnis_o), 25);
      end
    end
    chk("held_start_jobs", nvalid, 1);
    chk("held_start_mods", nms, 2);
    start_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_job(vecs[i].a, vecs[i].b, 1'b0, 2000);
      $display("job %0d,%0d -> got=%0b ergebnis=%0d error=%0b iter=%0d lat=%0d",
               vecs[i].a, vecs[i].b, r_got, r_res, r_err, r_iter, r_lat);
      chk("vec_valid_seen", 32'(r_got), 1);
      chk("vec_ergebnis", 32'(r_res), 32'(vecs[i].res));
      chk("vec_error", 32'(r_err), 32'(vecs[i].err));
      chk("vec_iter", 32'(r_iter), 32'(vecs[i].iter));
      chk("vec_mod_starts", r_nmods, 32'(vecs[i].iter));
      chk("vec_busy_at_valid", 32'(r_busy_at_v), 0);
      if (vecs[i].b == '0) begin
        chk("direct_latency", r_lat, 1);
      end else begin
        chk("first_mod_start_n1", 32'(r_first_ms), 1);
        chk("valid_after_r0", r_lat, r_kz + 1);
        chk("busy_before_valid", 32'(r_busy_prev), 1);
        chk("mod_operands_stable", 32'(r_stable), 1);
      end
      @(negedge clk);
      chk("valid_one_cycle", 32'(valid_o), 0);
      chk("ergebnis_hold", 32'(ergebnis_o), 32'(vecs[i].res));
    end

    // Remainder sequence and operand pairs
    run_job(16'd24255, 16'd9540, 1'b0, 2000);
    chk("rem_count", rem_q.size(), 8);
    for (int j = 0; j < 8 && j < rem_q.size(); j++) chk("rem_value", 32'(rem_q[j]), exp_rem[j]);
    @(negedge clk);
    run_job(16'd12, 16'd18, 1'b0, 2000);
    chk("pair_count", pa_q.size(), 3);
    for (int j = 0; j < 3 && j < pa_q.size(); j++) begin
      chk("pair_dividend", 32'(pa_q[j]), exp_pa[j]);
      chk("pair_divisor", 32'(pb_q[j]), exp_pb[j]);
    end
    @(negedge clk);

    // Timeout: modulo stage never answers, start_i held high afterwards.
    model_en = 1'b0;
    run_job(16'd24255, 16'd9540, 1'b1, TO + 200);
    $display("timeout job -> got=%0b ergebnis=%0d error=%0b iter=%0d lat=%0d",
             r_got, r_res, r_err, r_iter, r_lat);
    chk("timeout_valid_seen", 32'(r_got), 1);
    chk("timeout_latency", r_lat, TO + 2);
    chk("timeout_error", 32'(r_err), 1);
    chk("timeout_ergebnis", 32'(r_res), 0);
    chk("timeout_iter", 32'(r_iter), 1);
    quiet = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy_o || mod_start_o || valid_o) quiet = 0;
    end
    chk("held_start_no_rejob", 32'(quiet), 1);
    start_i = 1'b0;
    model_en = 1'b1;
    @(negedge clk);

    // Iteration cap: remainder never reaches zero.
    model_fake = 1'b1;
    run_job(16'd24255, 16'd9540, 1'b0, 2000);
    $display("cap job -> got=%0b error=%0b iter=%0d mods=%0d", r_got, r_err, r_iter, r_nmods);
    chk("cap_valid_seen", 32'(r_got), 1);
    chk("cap_error", 32'(r_err), 1);
    chk("cap_iter", 32'(r_iter), 63);
    chk("cap_mod_starts", r_nmods, 63);
    model_fake = 1'b0;
    repeat (5) @(negedge clk);

    // Reset during the second WAIT of the 24255/9540 job.
    pa_q.delete(); pb_q.delete();
    Zahl1_i = 16'd24255; Zahl2_i = 16'd9540; start_i = 1'b1;
    nms = 0;
    for (int k = 0; k < 100 && nms < 2; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (mod_start_o) nms++;
    end
    chk("reset_job_second_issue", nms, 2);
    @(negedge clk);
    chk("reset_job_in_wait", 32'(busy_o && !mod_start_o), 1);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_valid", 32'(valid_o), 0);
    chk("midrst_error", 32'(error_o), 0);
    chk("midrst_ergebnis", 32'(ergebnis_o), 0);
    chk("midrst_iter", 32'(iter_o), 0);
    chk("midrst_zahl1", 32'(mod_zahl1_o), 0);
    chk("midrst_zahl2", 32'(mod_zahl2_o), 0);
    @(negedge clk);
    rst = 1'b1;
    quiet = 1; nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mod_valid_i) nvalid++;
      if (valid_o || busy_o || mod_start_o) quiet = 0;
    end
    chk("late_mod_valid_seen", nvalid, 1);
    chk("late_mod_valid_ignored", 32'(quiet), 1);
    run_job(16'd24255, 16'd9540, 1'b0, 2000);
    $display("post-reset job -> got=%0b ergebnis=%0d error=%0b iter=%0d",
             r_got, r_res, r_err, r_iter);
    chk("post_reset_valid", 32'(r_got), 1);
    chk("post_reset_ergebnis", 32'(r_res), 45);
    chk("post_reset_iter", 32'(r_iter), 8);
    chk("post_reset_error", 32'(r_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ggt_sequencer.md
GGT_SEQUENCER -- requirements
Module: ggt_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand and result width.
REQ-002 SHALL have parameter TIMEOUT, default 1023, the maximum cycles to wait for one modulo result.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_i  input  1  job request; rising edge accepted when idle.
REQ-006 SHALL have port Zahl1_i  input  WIDTH  first GCD operand a.
REQ-007 SHALL have port Zahl2_i  input  WIDTH  second GCD operand b.
REQ-008 SHALL have port busy_o  output  1  job in progress.
REQ-009 SHALL have port valid_o  output  1  one-cycle pulse: ergebnis_o/error_o/iter_o valid.
REQ-010 SHALL have port ergebnis_o  output  WIDTH  gcd(a,b).
REQ-011 SHALL have port error_o  output  1  job ended abnormally (0,0 operands or timeout).
REQ-012 SHALL have port iter_o  output  6  number of modulo operations issued for the job.
REQ-013 SHALL have port mod_start_o  output  1  one-cycle start pulse to the downstream modulo stage.
REQ-014 SHALL have ports mod_zahl1_o and mod_zahl2_o  output  WIDTH  dividend and divisor to the modulo stage.
REQ-015 SHALL have port mod_valid_i  input  1  modulo stage result valid.
REQ-016 SHALL have port mod_ergebnis_i  input  WIDTH  remainder from the modulo stage.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-018 SHALL detect a start edge as start_i=1 while the registered previous start_i=0; previous-sample register resets to 0, so start_i held high through reset yields exactly one job.
REQ-019 IDLE: on start edge capture A=Zahl1_i, B=Zahl2_i, clear iteration count and watchdog, set busy_o=1 next cycle; start edges while busy_o=1 SHALL be ignored.
REQ-020 IDLE with start edge and B=0: go to DONE directly, ergebnis=A, iter=0, no mod_start_o; if also A=0, error=1 and ergebnis=0.
REQ-021 ISSUE: assert mod_start_o for exactly one cycle with mod_zahl1_o=A, mod_zahl2_o=B, increment iteration count, go to WAIT.
REQ-022 mod_zahl1_o/mod_zahl2_o SHALL remain stable from ISSUE until mod_valid_i is accepted.
REQ-023 WAIT: on mod_valid_i=1 with R=mod_ergebnis_i: if R=0 go to DONE with ergebnis=B; else A<=B, B<=R, go to ISSUE.
REQ-024 A<B requires no special case; the first modulo returns A and swaps naturally.
REQ-025 mod_valid_i outside WAIT SHALL be ignored.
REQ-026 WAIT: watchdog increments each cycle; reaching TIMEOUT without mod_valid_i SHALL go to DONE with error=1, ergebnis=0.
REQ-027 Iteration count SHALL saturate at 63; reaching 63 without R=0 SHALL go to DONE with error=1.
REQ-028 DONE: valid_o=1 for exactly one cycle, busy_o drops the same cycle, return to IDLE; ergebnis_o, error_o, iter_o hold until the next job completes.
REQ-029 Minimum latency: start edge cycle N, first mod_start_o at N+1; valid_o one cycle after the accepted mod_valid_i with R=0.

Reset
REQ-030 On rst=0, asynchronously: state IDLE, busy_o, valid_o, error_o, mod_start_o=0, ergebnis_o, iter_o, mod_zahl1_o, mod_zahl2_o, internal A/B/counters=0.
REQ-031 Reset mid-job SHALL abandon the job without emitting valid_o; a mod_valid_i arriving after release SHALL be ignored.

Verification (bench drives a behavioural modulo model, fixed latency 3 cycles unless stated)
REQ-032 Zahl1=24255, Zahl2=9540, start edge -> remainders 5175,4365,810,315,180,135,45,0; valid_o pulse, ergebnis_o=45, iter_o=8, error_o=0.
REQ-033 Zahl1=12, Zahl2=18 -> mod pairs (12,18),(18,12),(12,6); ergebnis_o=6, iter_o=3.
REQ-034 Zahl1=7, Zahl2=0 -> valid_o at N+1, ergebnis_o=7, iter_o=0, mod_start_o never asserted; Zahl1=0, Zahl2=0 -> ergebnis_o=0, error_o=1.
REQ-035 Model never returns valid -> valid_o with error_o=1, ergebnis_o=0 exactly TIMEOUT cycles after WAIT entry; start_i held high afterwards -> no new job.
REQ-036 rst=0 during second WAIT of the 24255/9540 job -> all outputs 0 immediately, no valid_o; late mod_valid_i ignored; new start edge -> correct 45.
